param_data_memory: RTL and testbench
====================================

Name: param_data_memory

Overview:
Parametrised single-port data memory for the datapath's MEM stage. It generalises the 8-bit × 32 data store in three ways: configurable width and depth, a selectable read latency, and a sequential reset-initialisation engine. The engine loads one word per cycle, replacing a single-cycle bulk load, and holds off accesses with a busy flag. Out-of-range accesses are detected and flagged instead of aliasing.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address port width in bits
DEPTH, 32, number of words; must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2
READ_LATENCY, 0, 0 = combinational read; 1 = registered read
INIT_MODE, 1, 0 = fill all words with zero; 1 = fill word i with i[DATA_W-1:0]

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
address  input  ADDR_W  word address
writedata  input  DATA_W  write data
memread  input  1  read request
memwrite  input  1  write request
readdata  output  DATA_W  read data
rvalid  output  1  readdata valid for the current read
busy  output  1  initialisation in progress; accesses ignored
addr_err  output  1  one-cycle pulse, registered: previous-cycle access had address >= DEPTH

Behaviour:
- Reset is asynchronous, active-high, on RESET; clock is CLK.
- State machine states: INIT, READY.
- While RESET=1: state=INIT, init_ptr=0, busy=1, addr_err=0, rvalid=0, readdata=0 (including the registered path).
- Memory contents are not cleared asynchronously; the INIT sweep rewrites them.
- INIT: each CLK edge writes mem[init_ptr] = pattern(init_ptr), then init_ptr++.
- INIT exit: on the edge that writes word DEPTH-1, go to READY. busy falls in the cycle after that edge, so INIT lasts exactly DEPTH cycles.
- All DEPTH words are initialised, including the last one.
- RESET asserted mid-INIT or in READY: return to INIT with init_ptr=0 and restart the full sweep.
- During INIT: memwrite and memread are ignored, rvalid=0, readdata=0, addr_err stays 0.
- READY, write: memwrite=1 and address<DEPTH → mem[address] = writedata on the CLK edge.
- READY, out-of-range access: address >= DEPTH with memwrite or memread → write dropped, read returns 0 with rvalid still asserted per latency rules, addr_err=1 for the following cycle.
- READ_LATENCY=0: readdata = mem[address] combinationally when memread=1, state=READY and address<DEPTH; otherwise 0. rvalid = memread & READY (combinational).
- READ_LATENCY=1: readdata and rvalid are registered; the value sampled at edge N is presented in cycle N+1.
  - rvalid=1 only in the cycle after an accepted memread; readdata holds its last value when no read is accepted.
- Read-during-write, same address: READ_LATENCY=0 shows writedata after the edge (memory updated). READ_LATENCY=1 returns the OLD word (read-first).
- memread=1 and memwrite=1 in the same cycle is legal; both are performed under the rules above.
- Index arithmetic: init_ptr is $clog2(DEPTH) bits with no wrap beyond DEPTH-1. Pattern i is truncated to DATA_W bits (e.g. DATA_W=4, i=20 → 4).
- Address compare uses the full ADDR_W bits; there is no modulo aliasing.

Test Plan:
- Default params; pulse RESET for 2 cycles → busy=1 for exactly 32 cycles after release. Then read addresses 0, 17, 31 → 0x00, 0x11, 0x1F, with rvalid=1.
- READY: write 0xA5 to address 5, then read 5 → 0xA5. READ_LATENCY=1 build: a same-cycle read/write to 5 returns the old value 0x05, and the next read returns 0xA5.
- Write 0x77 to address 40 (>= DEPTH=32) → addr_err=1 for one cycle. A subsequent read of 40 returns 0 with addr_err=1; words 0..31 are unchanged (spot-check 8 → 0x08).
- Assert RESET at init_ptr=12 → busy stays 1, then 32 full cycles after release. An earlier write of 0xA5 to word 5 is overwritten back to 0x05.
- During INIT, drive memwrite=1, address=3, writedata=0xFF → ignored; after INIT, word 3 reads 0x03 and rvalid stays 0 throughout INIT.
- DATA_W=16, DEPTH=64, INIT_MODE=0, READ_LATENCY=1 → INIT lasts 64 cycles and all words read 0x0000 one cycle after memread. Writing 0xBEEF to 63 and reading it back returns 0xBEEF.

Source files
------------

// File: rtl/param_data_memory.sv
// param_data_memory: parametrised single-port data memory with a one-word-per-cycle
// initialisation sweep, selectable read latency and out-of-range access flagging.
module param_data_memory #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 0,
  parameter int INIT_MODE    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  output logic              rvalid,
  output logic              busy,
  output logic              addr_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] init_ptr_q, init_ptr_d;
  logic addr_err_q, addr_err_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic ready, in_range, mem_we;
  logic [PW-1:0] idx, mem_wa;
  logic [DATA_W-1:0] mem_wd, rd_word;
  always_comb begin
    ready      = state_q == READY;
    in_range   = {1'b0, address} < DEPTH_A;
    idx        = address[PW-1:0];
    rd_word    = in_range ? mem[idx] : '0;
    state_d    = (state_q == INIT && init_ptr_q == LAST) ? READY : state_q;
    init_ptr_d = (!ready && init_ptr_q != LAST) ? init_ptr_q + 1'b1 : init_ptr_q;
    // The sweep owns the write port until the last word is written
    mem_we     = ready ? memwrite & in_range : 1'b1;
    mem_wa     = ready ? idx : init_ptr_q;
    mem_wd     = ready ? writedata : (INIT_MODE != 0 ? DATA_W'(init_ptr_q) : '0);
    addr_err_d = ready & (memread | memwrite) & ~in_range;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      addr_err_q <= addr_err_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  if (READ_LATENCY == 0) begin : g_comb
    always_comb begin
      rvalid   = memread & ready;
      readdata = rvalid ? rd_word : '0;
    end
  end else begin : g_reg
    logic rvalid_q, rvalid_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    // Read-first: the word sampled here is the pre-write contents
    always_comb begin
      rvalid_d   = memread & ready;
      readdata_d = rvalid_d ? rd_word : readdata_q;
    end
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        rvalid_q   <= 1'b0;
        readdata_q <= '0;
      end else begin
        rvalid_q   <= rvalid_d;
        readdata_q <= readdata_d;
      end
    end
    assign rvalid   = rvalid_q;
    assign readdata = readdata_q;
  end
  assign busy     = ~ready;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: checks a default instance (combinational read) and a
// 16-bit x 64 zero-init registered-read instance against array models.
module tb_param_data_memory;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] a0, wd0, q0;
  logic rd0, wr0, rv0, busy0, err0;
  logic [7:0] a1;
  logic [15:0] wd1, q1;
  logic rd1, wr1, rv1, busy1, err1;
  int n_checks, n_fail;
  logic [7:0] m0 [32];
  logic [15:0] m1 [64];
  logic [15:0] last1;
  always #5 CLK = ~CLK;
  param_data_memory u0 (
    .CLK(CLK), .RESET(RESET), .address(a0), .writedata(wd0), .memread(rd0),
    .memwrite(wr0), .readdata(q0), .rvalid(rv0), .busy(busy0), .addr_err(err0)
  );
  param_data_memory #(.DATA_W(16), .DEPTH(64), .READ_LATENCY(1), .INIT_MODE(0)) u1 (
    .CLK(CLK), .RESET(RESET), .address(a1), .writedata(wd1), .memread(rd1),
    .memwrite(wr1), .readdata(q1), .rvalid(rv1), .busy(busy1), .addr_err(err1)
  );
  task automatic model_init();
    for (int i = 0; i < 32; i++) m0[i] = 8'(i);
    for (int i = 0; i < 64; i++) m1[i] = '0;
    last1 = '0;
  endtask
  task automatic idle();
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    @(negedge CLK);
  endtask
  task automatic test_reset();
    int c0, c1;
    RESET = 1; rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 1/1", busy0, busy1);
    end
    n_checks++;
    if ({rv0, err0, rv1, err1} !== 4'b0 || q0 !== 8'h0 || q1 !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs: got rv/err %b%b%b%b q %h/%h want 0000 0/0", rv0, err0, rv1, err1, q0, q1);
    end
    RESET = 0; c0 = 0; c1 = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!busy0 && !busy1) break;
      if (busy0) begin
        c0++; n_checks++;
        if (rv0 !== 1'b0 || q0 !== 8'h0 || err0 !== 1'b0) begin
          n_fail++; $display("FAIL init_quiet0: got rv %b q %h err %b want 0 00 0", rv0, q0, err0);
        end
      end
      if (busy1) begin
        c1++; n_checks++;
        if (rv1 !== 1'b0 || q1 !== 16'h0 || err1 !== 1'b0) begin
          n_fail++; $display("FAIL init_quiet1: got rv %b q %h err %b want 0 0000 0", rv1, q1, err1);
        end
      end
      wr0 = busy0; rd0 = busy0; a0 = 8'd3; wd0 = 8'hFF;
      wr1 = busy1; rd1 = busy1; a1 = 8'd70; wd1 = 16'hFFFF;
      @(negedge CLK);
    end
    idle();
    n_checks++;
    if (c0 != 32 || c1 != 64) begin
      n_fail++; $display("FAIL init_length: got %0d/%0d want 32/64", c0, c1);
    end
    model_init();
  endtask
  task automatic test_init_values();
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) begin
        n_checks++;
        if (rv1 !== 1'b1 || q1 !== m1[i-1]) begin
          n_fail++; $display("FAIL init_word1[%0d]: got rv %b q %h want 1 %h", i-1, rv1, q1, m1[i-1]);
        end
      end
      rd1 = (i < 64); a1 = 8'(i);
      if (i < 32) begin
        rd0 = 1; a0 = 8'(i); #1;
        n_checks++;
        if (rv0 !== 1'b1 || q0 !== m0[i]) begin
          n_fail++; $display("FAIL init_word0[%0d]: got rv %b q %h want 1 %h", i, rv0, q0, m0[i]);
        end
      end else rd0 = 0;
      @(negedge CLK);
    end
    last1 = m1[63];
    idle();
  endtask
  task automatic test_write_read();
    wr0 = 1; a0 = 8'd5; wd0 = 8'hA5;
    @(negedge CLK); m0[5] = 8'hA5;
    wr0 = 0; rd0 = 1; #1;
    n_checks++;
    if (rv0 !== 1'b1 || q0 !== m0[5]) begin
      n_fail++; $display("FAIL wr_rd0: got %h want %h", q0, m0[5]);
    end
    @(negedge CLK);
    wr0 = 1; rd0 = 1; a0 = 8'd9; wd0 = 8'h3C; #1;
    n_checks++;
    if (q0 !== m0[9]) begin
      n_fail++; $display("FAIL raw0_before: got %h want %h", q0, m0[9]);
    end
    @(negedge CLK); m0[9] = 8'h3C; #1;
    n_checks++;
    if (q0 !== m0[9]) begin
      n_fail++; $display("FAIL raw0_after: got %h want %h", q0, m0[9]);
    end
    @(negedge CLK);
    rd0 = 0; wr0 = 0;
    wr1 = 1; a1 = 8'd63; wd1 = 16'hBEEF;
    @(negedge CLK); m1[63] = 16'hBEEF;
    wr1 = 0; rd1 = 1;
    @(negedge CLK); last1 = m1[63];
    n_checks++;
    if (rv1 !== 1'b1 || q1 !== last1) begin
      n_fail++; $display("FAIL wr_rd1: got rv %b q %h want 1 %h", rv1, q1, last1);
    end
    wr1 = 1; rd1 = 1; wd1 = 16'h1234;
    @(negedge CLK); last1 = m1[63]; m1[63] = 16'h1234;
    n_checks++;
    if (rv1 !== 1'b1 || q1 !== last1) begin
      n_fail++; $display("FAIL raw1_old: got %h want %h", q1, last1);
    end
    wr1 = 0;
    @(negedge CLK); last1 = m1[63];
    n_checks++;
    if (q1 !== last1) begin
      n_fail++; $display("FAIL raw1_new: got %h want %h", q1, last1);
    end
    rd1 = 0;
    @(negedge CLK);
    n_checks++;
    if (rv1 !== 1'b0 || q1 !== last1) begin
      n_fail++; $display("FAIL hold1: got rv %b q %h want 0 %h", rv1, q1, last1);
    end
    idle();
  endtask
  task automatic test_addr_err();
    logic [7:0] probe [3];
    probe[0] = 8'd31; probe[1] = 8'd32; probe[2] = 8'd255;
    wr0 = 1; a0 = 8'd40; wd0 = 8'h77;
    @(negedge CLK); wr0 = 0; #1;
    n_checks++;
    if (err0 !== 1'b1) begin
      n_fail++; $display("FAIL err_write: got %b want 1", err0);
    end
    @(negedge CLK);
    n_checks++;
    if (err0 !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got %b want 0", err0);
    end
    rd0 = 1; #1;
    n_checks++;
    if (rv0 !== 1'b1 || q0 !== 8'h00) begin
      n_fail++; $display("FAIL err_read: got rv %b q %h want 1 00", rv0, q0);
    end
    @(negedge CLK); rd0 = 0;
    n_checks++;
    if (err0 !== 1'b1) begin
      n_fail++; $display("FAIL err_read_flag: got %b want 1", err0);
    end
    for (int i = 0; i < 3; i++) begin
      rd0 = 1; a0 = probe[i];
      @(negedge CLK); rd0 = 0;
      n_checks++;
      if (err0 !== (probe[i] >= 8'd32)) begin
        n_fail++; $display("FAIL err_bound[%0d]: got %b want %b", probe[i], err0, probe[i] >= 8'd32);
      end
    end
    rd0 = 1; a0 = 8'd8; #1;
    n_checks++;
    if (q0 !== m0[8]) begin
      n_fail++; $display("FAIL err_intact: got %h want %h", q0, m0[8]);
    end
    @(negedge CLK); rd0 = 0;
    rd1 = 1; a1 = 8'd64;
    @(negedge CLK); rd1 = 0; last1 = 16'h0;
    n_checks++;
    if (rv1 !== 1'b1 || q1 !== last1 || err1 !== 1'b1) begin
      n_fail++; $display("FAIL err1: got rv %b q %h err %b want 1 0000 1", rv1, q1, err1);
    end
    idle();
  endtask
  task automatic test_random();
    logic exp_rv1, exp_err0, exp_err1;
    logic [7:0] e0;
    exp_rv1 = 0; exp_err0 = 0; exp_err1 = 0;
    for (int i = 0; i <= 300; i++) begin
      n_checks++;
      if (err0 !== exp_err0 || err1 !== exp_err1) begin
        n_fail++; $display("FAIL rnd_err[%0d]: got %b/%b want %b/%b", i, err0, err1, exp_err0, exp_err1);
      end
      n_checks++;
      if (rv1 !== exp_rv1 || q1 !== last1) begin
        n_fail++; $display("FAIL rnd_rd1[%0d]: got rv %b q %h want %b %h", i, rv1, q1, exp_rv1, last1);
      end
      if (i == 300) break;
      rd0 = 1'($urandom_range(0, 1)); wr0 = ($urandom_range(0, 2) == 0);
      a0 = 8'($urandom_range(0, 40)); wd0 = 8'($urandom);
      rd1 = 1'($urandom_range(0, 1)); wr1 = ($urandom_range(0, 2) == 0);
      a1 = 8'($urandom_range(0, 70)); wd1 = 16'($urandom);
      e0 = 8'h00;
      if (rd0 && a0 < 8'd32) e0 = m0[a0[4:0]];
      #1;
      n_checks++;
      if (rv0 !== rd0 || q0 !== e0) begin
        n_fail++; $display("FAIL rnd_rd0[%0d]: got rv %b q %h want %b %h", i, rv0, q0, rd0, e0);
      end
      exp_err0 = (rd0 | wr0) && (a0 >= 8'd32);
      exp_err1 = (rd1 | wr1) && (a1 >= 8'd64);
      exp_rv1 = rd1;
      if (rd1) last1 = (a1 < 8'd64) ? m1[a1[5:0]] : 16'h0;
      if (wr0 && a0 < 8'd32) m0[a0[4:0]] = wd0;
      if (wr1 && a1 < 8'd64) m1[a1[5:0]] = wd1;
      @(negedge CLK);
    end
    idle();
  endtask
  task automatic test_reset_mid_init();
    int c0, c1;
    wr0 = 1; a0 = 8'd5; wd0 = 8'hA5;
    @(negedge CLK); wr0 = 0; rd0 = 1; rd1 = 1; a1 = 8'd63; #1;
    n_checks++;
    if (q0 !== 8'hA5) begin
      n_fail++; $display("FAIL mid_pre: got %h want a5", q0);
    end
    RESET = 1; #1;
    n_checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || rv0 !== 1'b0 || q0 !== 8'h0 || rv1 !== 1'b0 || q1 !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: got busy %b%b rv %b%b q %h/%h want 11 00 0/0", busy0, busy1, rv0, rv1, q0, q1);
    end
    rd0 = 0; rd1 = 0;
    @(negedge CLK); RESET = 0;
    repeat (12) @(negedge CLK);
    RESET = 1; #1;
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b want 1", busy0);
    end
    @(negedge CLK); RESET = 0;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!busy0 && !busy1) break;
      if (busy0) c0++;
      if (busy1) c1++;
      @(negedge CLK);
    end
    @(negedge CLK);
    n_checks++;
    if (c0 != 32 || c1 != 64) begin
      n_fail++; $display("FAIL mid_length: got %0d/%0d want 32/64", c0, c1);
    end
    model_init();
    rd0 = 1; a0 = 8'd5; rd1 = 1; a1 = 8'd63; #1;
    n_checks++;
    if (q0 !== m0[5]) begin
      n_fail++; $display("FAIL mid_word5: got %h want %h", q0, m0[5]);
    end
    @(negedge CLK); last1 = m1[63];
    n_checks++;
    if (rv1 !== 1'b1 || q1 !== last1) begin
      n_fail++; $display("FAIL mid_word63: got rv %b q %h want 1 %h", rv1, q1, last1);
    end
    idle();
  endtask
  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_init_values();
    test_write_read();
    test_addr_err();
    test_random();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
